// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end.
//   fetch_state_t    : instruction-fetch FSM states
//   NOP_INSTR        : all-zero MIPS sll $0,$0,0 used for squashed slots
//   WORD_BYTES       : instruction size, the sequential PC stride
//   DEFAULT_RESET_PC : first fetch address unless overridden
package mips_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES       = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Branch targets are word addresses; the two low bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_register.sv
// Fetch program counter: 32-bit register with async active-low reset to
// RESET_PC. When load is high it takes either the sequential successor
// (pc + WORD_BYTES, wrapping at 2^32) or an externally supplied target.
//   clock, reset_n : clock / async active-low reset
//   load           : update enable
//   sel_target     : 1 = load target, 0 = load pc + WORD_BYTES
//   target         : redirect address (already word aligned)
//   pc             : current fetch address
module pc_register
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        load,
    input  logic        sel_target,
    input  logic [31:0] target,
    output logic [31:0] pc
);

    logic [31:0] next_pc;

    assign next_pc = sel_target ? target : (pc + WORD_BYTES);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= next_pc;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage in front of a synchronous-read instruction memory
// (data returns one cycle after the address). Presents one instruction per
// cycle with its PC, holds it while the CPU stalls, and follows redirects.
//
// Ports:
//   clock, reset_n      : clock / async active-low reset
//   stall               : CPU did not consume the current instruction
//   redirect_valid      : taken branch/jump this cycle
//   redirect_target     : branch/jump byte address (low bits cleared here)
//   imem_addr/imem_data : instruction memory address / read data
//   instruction         : instruction word to the CPU (NOP when invalid)
//   instr_valid         : instruction is valid
//   pc_out, pc_plus4    : byte address of instruction, and that plus 4
//   err_misaligned      : sticky, set by a redirect with target[1:0] != 0
//
// Build option: define FETCH_DELAY_SLOT_EN to deliver the instruction already
// in flight behind a branch (MIPS delay slot) instead of squashing it.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        err_misaligned
);

    // With a delay slot the in-flight word is useful, so a redirect keeps
    // running; otherwise one FLUSH cycle hides the wrong-path word.
`ifdef FETCH_DELAY_SLOT_EN
    localparam fetch_state_t REDIRECT_STATE = RUN;
`else
    localparam fetch_state_t REDIRECT_STATE = FLUSH;
`endif

    fetch_state_t state, state_next;

    logic [31:0] fetch_pc;     // address currently presented to memory
    logic [31:0] addr_q;       // address of the word now on imem_data
    logic [31:0] hold_instr;
    logic [31:0] hold_pc;
    logic        pc_load;
    logic        pc_sel_target;
    logic        capture_hold;
    logic        take_redirect;

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (pc_load),
        .sel_target (pc_sel_target),
        .target     (word_align(redirect_target)),
        .pc         (fetch_pc)
    );

    assign imem_addr     = fetch_pc;
    assign take_redirect = redirect_valid && (state != BOOT);
    assign pc_plus4      = pc_out + WORD_BYTES;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // addr_q tracks memory latency: whatever was addressed last cycle is
    // what imem_data carries now. In HOLD the address is frozen, so on
    // leaving HOLD imem_data already holds the next word (no bubble).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q         <= RESET_PC;
            hold_instr     <= NOP_INSTR;
            hold_pc        <= RESET_PC;
            err_misaligned <= 1'b0;
        end else begin
            addr_q <= imem_addr;
            if (capture_hold) begin
                hold_instr <= imem_data;
                hold_pc    <= addr_q;
            end
            if (take_redirect && (redirect_target[1:0] != 2'b00)) begin
                err_misaligned <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next    = state;
        pc_load       = 1'b0;
        pc_sel_target = 1'b0;
        capture_hold  = 1'b0;
        instr_valid   = 1'b0;
        instruction   = NOP_INSTR;
        pc_out        = addr_q;

        case (state)
            BOOT: begin
                // Address RESET_PC this cycle, step to RESET_PC+4.
                pc_load    = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                instr_valid = 1'b1;
                instruction = imem_data;
                if (stall) begin
                    capture_hold = 1'b1;
                    state_next   = HOLD;
                end else begin
                    pc_load = 1'b1;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                instruction = hold_instr;
                pc_out      = hold_pc;
                if (!stall) begin
                    pc_load    = 1'b1;
                    state_next = RUN;
                end
            end
            FLUSH: begin
                // Target word is being read; it appears next cycle in RUN.
                pc_load    = 1'b1;
                state_next = RUN;
            end
            default: begin
                state_next = BOOT;
            end
        endcase

        // A redirect overrides stall handling in every state but BOOT.
        if (take_redirect) begin
            pc_load       = 1'b1;
            pc_sel_target = 1'b1;
            capture_hold  = 1'b0;
            state_next    = REDIRECT_STATE;
        end
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clock  input  1  meaning the single rising-edge clock for all state.
REQ-003 SHALL have port reset_n  input  1  meaning reset, asynchronous, active-low.
REQ-004 SHALL have port stall  input  1  meaning the downstream CPU does not consume the current instruction this cycle.
REQ-005 SHALL have port redirect_valid  input  1  meaning a taken branch or jump this cycle.
REQ-006 SHALL have port redirect_target  input  32  meaning the branch or jump byte address.
REQ-007 SHALL have port imem_addr  output  32  meaning the instruction memory address; memory is synchronous-read with data valid one cycle later.
REQ-008 SHALL have port imem_data  input  32  meaning the instruction memory read data.
REQ-009 SHALL have port instruction  output  32  meaning the instruction word fed to mips_cpu.
REQ-010 SHALL have port instr_valid  output  1  meaning instruction is valid this cycle.
REQ-011 SHALL have port pc_out  output  32  meaning the byte address of the instruction output.
REQ-012 SHALL have port pc_plus4  output  32  meaning pc_out+4, modulo 2^32, for link and branch offset use.
REQ-013 SHALL have port err_misaligned  output  1  meaning a sticky flag set by a redirect target with bits [1:0] nonzero.

Function
REQ-014 SHALL implement the FSM states BOOT, RUN, HOLD and FLUSH.
REQ-015 BOOT SHALL last exactly one cycle after reset release, drive imem_addr=RESET_PC and instr_valid=0, then go to RUN with fetch_pc=RESET_PC+4.
REQ-016 RUN SHALL drive instruction=imem_data and instr_valid=1, with pc_out equal to the previous cycle's imem_addr.
REQ-017 In RUN with stall=0, fetch_pc SHALL advance by 4 each cycle.
REQ-018 RUN with stall=1 SHALL capture instruction and pc_out into hold registers and go to HOLD.
REQ-019 HOLD SHALL keep instruction, pc_out, instr_valid=1 and imem_addr stable.
REQ-020 HOLD with stall=0 SHALL go to RUN, and the next cycle SHALL output mem[imem_addr] with no bubble.
REQ-021 redirect_valid SHALL take priority over stall in any state except BOOT.
REQ-022 On redirect, imem_addr SHALL be {redirect_target[31:2],2'b00} in the next cycle.
REQ-023 With the delay slot disabled, a redirect SHALL go to FLUSH, which holds instr_valid=0 and instruction=32'h0 (NOP) for one cycle, then go to RUN.
REQ-024 A redirect_valid in FLUSH SHALL re-target and stay in FLUSH for one more cycle.
REQ-025 PC increment SHALL wrap 32'hFFFF_FFFC to 32'h0000_0000 with no error.
REQ-026 While instr_valid=0, instruction SHALL be 32'h0.
REQ-027 redirect_valid with target[1:0]!=0 SHALL set err_misaligned, which stays set until reset; the redirect is still taken with the low bits cleared.

Reset
REQ-028 On reset_n low, all state SHALL clear immediately, independent of clock: state=BOOT, imem_addr=RESET_PC, pc_out=RESET_PC, pc_plus4=RESET_PC+4, instruction=0, instr_valid=0, err_misaligned=0.
REQ-029 An in-flight fetch and held instruction SHALL be discarded when reset asserts mid-operation.
REQ-030 Release SHALL be synchronous to the next clock edge after reset_n goes high.

Configuration
REQ-031 The macro FETCH_DELAY_SLOT_EN SHALL select delay-slot behaviour.
REQ-032 When FETCH_DELAY_SLOT_EN is defined, the in-flight instruction at branch PC+4 SHALL be delivered with instr_valid=1, then the target instruction follows with no bubble, and FLUSH is unused.
REQ-033 When FETCH_DELAY_SLOT_EN is undefined, the in-flight instruction SHALL be squashed per REQ-023.

Structure
REQ-034 The shared package mips_pkg SHALL hold the fetch-state enum, the NOP_INSTR=32'h0 and WORD_BYTES=4 constants, and the default RESET_PC.
REQ-035 The block SHALL contain exactly one sub-module, pc_register: a 32-bit flop with asynchronous active-low reset to RESET_PC, load enable and a load-value mux.

Verification
REQ-036 Bench SHALL cover reset release with RESET_PC=0: cycle 1 instr_valid=0; cycle 2 instruction=mem[0], pc_out=0; cycle 3 pc_out=4.
REQ-037 Bench SHALL cover stall=1 for 3 cycles at pc_out=8: instruction and pc_out stay at mem[8] and 8; after release, pc_out=12 on the next cycle with no gap.
REQ-038 Bench SHALL cover redirect to 0x100 at pc_out=0x20 with the macro off: one instr_valid=0 cycle, then pc_out=0x100.
REQ-039 Bench SHALL cover the same redirect with FETCH_DELAY_SLOT_EN on: pc_out sequence 0x20, 0x24, 0x100.
REQ-040 Bench SHALL cover redirect target 0x102: err_misaligned=1 and held, pc_out=0x100; then PC 0xFFFF_FFFC followed by 0x0000_0000.
REQ-041 Bench SHALL cover simultaneous stall=1 and redirect_valid=1, plus reset_n pulsed low mid-HOLD: the redirect wins, and the reset clears instr_valid within the same cycle.
